// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Shared constants and types for the interrupt capture front end.
//   N      : number of request lines (only 8 is supported)
//   IDX_W  : width of a request index, log2(N)
//   state_t: grant handshake FSM states
// ----------------------------------------------------------------------------
package irq_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage : irq_pkg

// File: rtl/irq_sel.sv
// ----------------------------------------------------------------------------
// irq_sel
// Combinational masked highest-bit selector.
// Ports:
//   pending [N-1:0]     in  : pending request bits
//   mask    [N-1:0]     in  : 1 = request enabled
//   any                 out : at least one enabled request is pending
//   sel     [IDX_W-1:0] out : index of the highest enabled pending bit
//                             (0 when any is 0)
// ----------------------------------------------------------------------------
module irq_sel
  import irq_pkg::*;
(
  input  logic [N-1:0]     pending,
  input  logic [N-1:0]     mask,
  output logic             any,
  output logic [IDX_W-1:0] sel
);

  logic [N-1:0] masked;

  assign masked = pending & mask;
  assign any    = |masked;

  always_comb begin
    // NOTE: every combinational output gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    sel = '0;
    // Ascending scan: the last hit is the highest-numbered, i.e. highest
    // priority, request.
    for (int i = 0; i < N; i++) begin
      if (masked[i]) sel = IDX_W'(i);
    end
  end

endmodule : irq_sel

// File: rtl/irq_capture.sv
// ----------------------------------------------------------------------------
// irq_capture
// Edge-capturing interrupt front end. Rising edges on req_in are latched
// into a pending register; the highest-numbered enabled pending request is
// presented as irq_idx with irq_valid, held stable until irq_ack, and its
// pending bit is cleared on the acknowledging edge.
//
// Configuration macro:
//   IRQ_SYNC_EN : when defined, req_in passes through a 2-flop per-bit
//                 synchroniser before edge detection (4-cycle latency
//                 instead of 2). Port list is identical either way.
//
// Ports:
//   clk               in  : clock, all state updates on the rising edge
//   rst               in  : asynchronous, active-high reset
//   req_in  [N-1:0]   in  : raw request levels, bit 7 highest priority
//   mask    [N-1:0]   in  : 1 = request enabled (combinational each cycle)
//   irq_ack           in  : consumer accepts presented index (ISSUE only)
//   irq_valid         out : an index is being presented
//   irq_idx [IDX_W-1:0] out : presented request index
//   pending [N-1:0]   out : current pending register
//   overrun [N-1:0]   out : sticky, edge arrived on an already pending bit
// ----------------------------------------------------------------------------
module irq_capture
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overrun
);

  logic [N-1:0]     req_s;
  logic [N-1:0]     req_q;
  logic [N-1:0]     edge_det;
  logic [N-1:0]     clr;
  logic             any;
  logic [IDX_W-1:0] sel;
  state_t           state, state_d;
  logic [IDX_W-1:0] idx_d;

  // --------------------------------------------------------------------------
  // Request input stage
  // --------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= req_in;
      sync2 <= sync1;
    end
  end

  assign req_s = sync2;
`else
  assign req_s = req_in;
`endif

  // req_q resets to 0, so a line held high across reset release is seen as
  // one rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others.
      req_q <= req_s;
    end
  end

  assign edge_det = req_s & ~req_q;

  // --------------------------------------------------------------------------
  // Pending / overrun registers
  // --------------------------------------------------------------------------
  assign irq_valid = (state == ST_ISSUE);

  always_comb begin
    clr = '0;
    if (irq_valid && irq_ack) clr[irq_idx] = 1'b1;
  end

  // A set and a clear on the same bit in one cycle leaves the bit set; that
  // case is a fresh request, not an overrun, since the old one was consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= edge_det | (pending & ~clr);
      overrun <= overrun | (edge_det & pending & ~clr);
    end
  end

  // --------------------------------------------------------------------------
  // Selection and grant handshake
  // --------------------------------------------------------------------------
  irq_sel u_sel (
    .pending (pending),
    .mask    (mask),
    .any     (any),
    .sel     (sel)
  );

  // The selection is only consulted in IDLE; once in ISSUE the latched index
  // is held regardless of masking or higher-priority arrivals.
  always_comb begin
    state_d = state;
    idx_d   = irq_idx;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_ISSUE;
          idx_d   = sel;
        end
      end
      ST_ISSUE: begin
        if (irq_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      irq_idx <= '0;
    end else begin
      state   <= state_d;
      irq_idx <= idx_d;
    end
  end

endmodule : irq_capture

// File: tb/tb_irq_capture.sv
// ----------------------------------------------------------------------------
// tb_irq_capture
// Self-checking bench for irq_capture: table-driven grant/mask/pre-emption/
// overrun vectors plus hand-written latency, same-cycle ack+edge and
// asynchronous-reset sequences. Aware of IRQ_SYNC_EN through SYNC_EXTRA.
// ----------------------------------------------------------------------------
module tb_irq_capture;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif
  localparam int LAT = 2 + SYNC_EXTRA;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_idx;
  logic [7:0] pending;
  logic [7:0] overrun;

  int checks   = 0;
  int failures = 0;

  irq_capture dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_idx   (irq_idx),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pulse_v;   // if nonzero, pulse these request bits first
    logic [7:0] mask_v;
    logic       ack_v;
    logic       exp_valid;
    logic [2:0] exp_idx;   // compared only when exp_valid is 1
    logic [7:0] exp_pend;
    logic [7:0] exp_ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; afterwards the pending register holds the
  // edge in either configuration.
  task automatic pulse(input logic [7:0] v);
    req_in  = v;
    irq_ack = 1'b0;
    step();
    req_in = '0;
    repeat (SYNC_EXTRA) step();
  endtask

  function automatic vec_t mk(input logic [7:0] p, input logic [7:0] m,
                              input logic a, input logic v,
                              input logic [2:0] i, input logic [7:0] pe,
                              input logic [7:0] ov);
    vec_t r;
    r.pulse_v = p; r.mask_v = m; r.ack_v = a; r.exp_valid = v;
    r.exp_idx = i; r.exp_pend = pe; r.exp_ovr = ov;
    return r;
  endfunction

  initial begin
    // Priority order 7, 4, 0 with 1-cycle bubbles; ack in IDLE ignored.
    tbl.push_back(mk(8'h91, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h91, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h11, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd4, 8'h11, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h01, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h01, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
    // Masked pending bit is not granted until unmasked.
    tbl.push_back(mk(8'h10, 8'hEF, 1'b0, 1'b0, 3'd0, 8'h10, 8'h00));
    tbl.push_back(mk(8'h00, 8'hEF, 1'b1, 1'b0, 3'd0, 8'h10, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd4, 8'h10, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
    // Masking the presented bit and a higher arrival do not pre-empt.
    tbl.push_back(mk(8'h08, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00));
    tbl.push_back(mk(8'h00, 8'hF7, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00));
    tbl.push_back(mk(8'h40, 8'hF7, 1'b0, 1'b1, 3'd3, 8'h48, 8'h00));
    tbl.push_back(mk(8'h00, 8'hF7, 1'b1, 1'b0, 3'd0, 8'h40, 8'h00));
    tbl.push_back(mk(8'h00, 8'hF7, 1'b0, 1'b1, 3'd6, 8'h40, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
    // Re-edge on a pending bit sets sticky overrun.
    tbl.push_back(mk(8'h20, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20, 8'h00));
    tbl.push_back(mk(8'h20, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20, 8'h20));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 8'h20));
    tbl.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 8'h20));

    rst     = 1'b1;
    req_in  = '0;
    mask    = 8'hFF;
    irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid",   {7'd0, irq_valid}, 8'h00);
    check("reset_idx",     {5'd0, irq_idx},   8'h00);
    check("reset_pending", pending,           8'h00);
    check("reset_overrun", overrun,           8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single pulse on bit 2: valid exactly LAT edges later.
    req_in = 8'h04;
    for (int c = 1; c <= LAT; c++) begin
      step();
      req_in = '0;
      check($sformatf("lat_valid_c%0d", c), {7'd0, irq_valid},
            {7'd0, (c == LAT)});
    end
    check("lat_idx",     {5'd0, irq_idx}, 8'h02);
    check("lat_pending", pending,         8'h04);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("lat_ack_valid",   {7'd0, irq_valid}, 8'h00);
    check("lat_ack_pending", pending,           8'h00);

    // Table-driven vectors.
    foreach (tbl[k]) begin
      mask = tbl[k].mask_v;
      if (tbl[k].pulse_v != 8'h00) pulse(tbl[k].pulse_v);
      irq_ack = tbl[k].ack_v;
      step();
      irq_ack = 1'b0;
      check($sformatf("vec%0d_valid", k), {7'd0, irq_valid},
            {7'd0, tbl[k].exp_valid});
      if (tbl[k].exp_valid)
        check($sformatf("vec%0d_idx", k), {5'd0, irq_idx},
              {5'd0, tbl[k].exp_idx});
      check($sformatf("vec%0d_pending", k), pending, tbl[k].exp_pend);
      check($sformatf("vec%0d_overrun", k), overrun, tbl[k].exp_ovr);
    end

    // Asynchronous reset in the middle of ISSUE (overrun[5] still set).
    mask = 8'hFF;
    pulse(8'h02);
    step();
    check("pre_rst_valid", {7'd0, irq_valid}, 8'h01);
    check("pre_rst_idx",   {5'd0, irq_idx},   8'h01);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid",   {7'd0, irq_valid}, 8'h00);
    check("async_rst_idx",     {5'd0, irq_idx},   8'h00);
    check("async_rst_pending", pending,           8'h00);
    check("async_rst_overrun", overrun,           8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Edge on bit 5 in the same cycle as its ack: set wins, no overrun.
    pulse(8'h20);
    step();
    check("same_pre_valid", {7'd0, irq_valid}, 8'h01);
    check("same_pre_idx",   {5'd0, irq_idx},   8'h05);
    for (int k = 0; k <= SYNC_EXTRA; k++) begin
      req_in  = (k == 0) ? 8'h20 : 8'h00;
      irq_ack = (k == SYNC_EXTRA);
      step();
    end
    req_in  = '0;
    irq_ack = 1'b0;
    check("same_valid",   {7'd0, irq_valid}, 8'h00);
    check("same_pending", pending,           8'h20);
    check("same_overrun", overrun,           8'h00);
    step();
    check("same_regrant_valid", {7'd0, irq_valid}, 8'h01);
    check("same_regrant_idx",   {5'd0, irq_idx},   8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_irq_capture
